// File: rtl/stonyman_scan.sv
`default_nettype none
//==============================================================================
// Module  : stonyman_scan
// Brief   : Pixel scan sequencer for the Stonyman imager. It drives the sensor
//           pointer pulses, applies the frame mask, runs the ADC and streams
//           the resulting samples.
// Revision: 1.0
//==============================================================================
module stonyman_scan #(
  parameter int RESOLUTION  = 112,
  parameter int PULSE_CYC   = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [6:0]  pixel_row,
  output logic [6:0]  pixel_col,
  input  logic        capture_pixel,
  output logic        resv,
  output logic        incv,
  output logic        resp,
  output logic        incp,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [9:0]  adc_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        adc_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RSTV   = 3'd1;
  localparam logic [2:0] S_RSTH   = 3'd2;
  localparam logic [2:0] S_MASK   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_CONV   = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;
  localparam logic [2:0] S_NEXT   = 3'd7;

  localparam logic [15:0] c_PULSE_HI   = 16'(PULSE_CYC);
  localparam logic [15:0] c_PULSE_END  = 16'(2 * PULSE_CYC - 1);
  localparam logic [15:0] c_SETTLE_END = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] c_ADC_END    = 16'(ADC_TIMEOUT - 1);
  localparam logic [6:0]  c_LAST       = 7'(RESOLUTION - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_cnt;
  logic [6:0]  r_row;
  logic [6:0]  r_col;
  logic [9:0]  r_data;
  logic        r_err;

  logic w_pulse_hi;
  logic w_pulse_end;
  logic w_col_last;
  logic w_row_last;
  logic w_timeout;

  assign w_pulse_hi  = (r_cnt < c_PULSE_HI);
  assign w_pulse_end = (r_cnt == c_PULSE_END);
  assign w_col_last  = (r_col == c_LAST);
  assign w_row_last  = (r_row == c_LAST);
  assign w_timeout   = (r_cnt == c_ADC_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Every state entry restarts the phase counter.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (frame_start) w_next = S_RSTV;
      S_RSTV:   if (w_pulse_end) w_next = S_RSTH;
      S_RSTH:   if (w_pulse_end) w_next = S_MASK;
      S_MASK:   if (r_cnt == 16'd1) w_next = capture_pixel ? S_SETTLE : S_NEXT;
      S_SETTLE: if (r_cnt == c_SETTLE_END) w_next = S_CONV;
      S_CONV: begin
        if (adc_done)       w_next = S_OUT;
        else if (w_timeout) w_next = S_NEXT;
      end
      S_OUT:    if (pix_ready) w_next = S_NEXT;
      S_NEXT: begin
        if (w_col_last && w_row_last) w_next = S_IDLE;
        else if (w_pulse_end)         w_next = w_col_last ? S_RSTH : S_MASK;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && frame_start) begin
        r_row <= '0;
        r_col <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_NEXT && w_next == S_RSTH) begin
        r_row <= r_row + 7'd1;
        r_col <= '0;
      end
      if (r_state == S_NEXT && w_next == S_MASK)
        r_col <= r_col + 7'd1;
      if (r_state == S_CONV && adc_done)
        r_data <= adc_data;
      if (r_state == S_CONV && !adc_done && w_timeout)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    frame_done = (r_state == S_NEXT) && w_col_last && w_row_last;
    busy       = (r_state != S_IDLE) && !frame_done;
    resv       = (r_state == S_RSTV) && w_pulse_hi;
    resp       = (r_state == S_RSTH) && w_pulse_hi;
    incp       = (r_state == S_NEXT) && !w_col_last && w_pulse_hi;
    incv       = (r_state == S_NEXT) && w_col_last && !w_row_last && w_pulse_hi;
    adc_start  = (r_state == S_CONV) && (r_cnt == 16'd0);
    pix_valid  = (r_state == S_OUT);
    pix_data   = {6'b0, r_data};
    pixel_row  = r_row;
    pixel_col  = r_col;
    adc_err    = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_stonyman_scan.sv
`default_nettype none
//==============================================================================
// Module  : tb_stonyman_scan
// Brief   : Directed self-checking bench for stonyman_scan on a reduced 8x8 array.
// Revision: 1.0
//==============================================================================
module tb_stonyman_scan;
  localparam int RES = 8;
  localparam int PW  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        busy, frame_done;
  logic [6:0]  pixel_row, pixel_col;
  logic        capture_pixel;
  logic        resv, incv, resp, incp;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [9:0]  adc_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic        adc_err;

  int total = 0;
  int bad   = 0;

  int   mode = 0;
  logic no_done00 = 1'b0;

  stonyman_scan #(
    .RESOLUTION(RES), .PULSE_CYC(PW), .SETTLE_CYC(8), .ADC_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .pixel_row(pixel_row), .pixel_col(pixel_col),
    .capture_pixel(capture_pixel), .resv(resv), .incv(incv), .resp(resp),
    .incp(incp), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  // Mask: 0 none, 1 all, 2 only (5,7)
  assign capture_pixel = (mode == 1) || (mode == 2 && pixel_row == 7'd5 && pixel_col == 7'd7);

  // ADC answers three cycles after a start with the current column
  int adc_wait = 0;
  always @(negedge clk) begin
    adc_done = 1'b0;
    if (adc_wait > 0) begin
      adc_wait--;
      if (adc_wait == 0) adc_done = 1'b1;
    end
    if (adc_start && !(no_done00 && pixel_row == 7'd0 && pixel_col == 7'd0)) begin
      adc_wait = 3;
      adc_data = {3'b0, pixel_col};
    end
  end

  int cyc = 0;
  int n_resv = 0, n_resp = 0, n_incv = 0, n_incp = 0;
  int n_start = 0, n_done = 0, n_acc = 0;
  int pw_err = 0, oh_err = 0, ord_err = 0;
  int ord_base = 0;
  int start_cyc = 0, err_cyc = -1;
  int run [4] = '{default: 0};
  logic [3:0]  prev = '0;
  logic        prev_err = 1'b0;
  logic [6:0]  acc_row = '0, acc_col = '0;
  logic [15:0] acc_data = '0;

  always @(negedge clk) begin
    logic [3:0] cur;
    int idx;
    cyc++;
    cur = {resv, resp, incv, incp};
    if ($countones(cur) > 1) oh_err++;
    for (int i = 0; i < 4; i++) begin
      if (cur[i] === 1'b1) run[i]++;
      else if (prev[i] === 1'b1) begin
        if (run[i] != PW) pw_err++;
        run[i] = 0;
      end
    end
    if (cur[3] && !prev[3]) n_resv++;
    if (cur[2] && !prev[2]) n_resp++;
    if (cur[1] && !prev[1]) n_incv++;
    if (cur[0] && !prev[0]) n_incp++;
    prev = cur;
    if (adc_start === 1'b1) begin n_start++; start_cyc = cyc; end
    if (frame_done === 1'b1) n_done++;
    if (adc_err === 1'b1 && !prev_err) err_cyc = cyc;
    prev_err = (adc_err === 1'b1);
    if (pix_valid === 1'b1 && pix_ready) begin
      idx = n_acc - ord_base;
      if (mode == 1 && !no_done00) begin
        if (pixel_row != 7'(idx / RES) || pixel_col != 7'(idx % RES) ||
            pix_data != {9'b0, pixel_col}) ord_err++;
      end
      acc_row  = pixel_row;
      acc_col  = pixel_col;
      acc_data = pix_data;
      n_acc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy !== 1'b0 && k < lim);
    chk(tag, {63'b0, busy}, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  int s_resv, s_resp, s_incv, s_incp, s_start, s_done, s_acc, k, good;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {25'b0, busy, frame_done, pixel_row, pixel_col, resv, incv, resp, incp,
         adc_start, pix_valid, pix_data, adc_err}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Mask all 0: pointer pulses only
    mode = 0; pix_ready = 1'b1;
    s_resv = n_resv; s_resp = n_resp; s_incv = n_incv; s_incp = n_incp;
    s_start = n_start; s_done = n_done;
    start_frame();
    wait_idle(5000, "t2_idle");
    chk("t2_resv", 64'(n_resv - s_resv), 64'd1);
    chk("t2_resp", 64'(n_resp - s_resp), 64'd8);
    chk("t2_incv", 64'(n_incv - s_incv), 64'd7);
    chk("t2_incp", 64'(n_incp - s_incp), 64'd56);
    chk("t2_adc_start", 64'(n_start - s_start), 64'd0);
    chk("t2_frame_done", 64'(n_done - s_done), 64'd1);

    // Mask all 1: every pixel sampled in row-major order
    mode = 1; ord_base = n_acc;
    s_start = n_start; s_done = n_done; s_acc = n_acc;
    start_frame();
    wait_idle(20000, "t1_idle");
    chk("t1_samples", 64'(n_acc - s_acc), 64'd64);
    chk("t1_order", 64'(ord_err), 64'd0);
    chk("t1_adc_start", 64'(n_start - s_start), 64'd64);
    chk("t1_frame_done", 64'(n_done - s_done), 64'd1);
    chk("t1_last_data", {48'b0, acc_data}, 64'd7);

    // Only (5,7) captured, with backpressure
    mode = 2; pix_ready = 1'b0;
    s_acc = n_acc; s_done = n_done;
    start_frame();
    k = 0;
    do begin @(negedge clk); k++; end while (pix_valid !== 1'b1 && k < 5000);
    chk("t3_valid_seen", {63'b0, pix_valid}, 64'd1);
    good = 1;
    repeat (49) begin
      @(negedge clk);
      if (pix_valid === 1'b1 && pix_data === 16'd7 && pixel_row === 7'd5 && pixel_col === 7'd7)
        good++;
    end
    chk("t3_held_cycles", 64'(good), 64'd50);
    chk("t3_no_accept_yet", 64'(n_acc - s_acc), 64'd0);
    @(posedge clk); #1 pix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_accepted", 64'(n_acc - s_acc), 64'd1);
    chk("t3_valid_dropped", {63'b0, pix_valid}, 64'd0);
    chk("t3_data", {48'b0, acc_data}, 64'd7);
    wait_idle(5000, "t3_idle");
    chk("t3_frame_done", 64'(n_done - s_done), 64'd1);

    // ADC timeout on (0,0); ignored frame_start mid-scan
    mode = 1; no_done00 = 1'b1;
    s_acc = n_acc; s_resv = n_resv; s_done = n_done;
    start_frame();
    k = 0;
    do begin @(negedge clk); k++; end while (adc_err !== 1'b1 && k < 2000);
    @(negedge clk);
    chk("t4_adc_err_set", {63'b0, adc_err}, 64'd1);
    chk("t4_timeout_cycles", 64'(err_cyc - start_cyc), 64'd255);
    chk("t4_no_sample_00", 64'(n_acc - s_acc), 64'd0);
    k = 0;
    do begin @(negedge clk); k++; end while (n_acc == s_acc && k < 200);
    chk("t4_next_pixel", {50'b0, acc_row, acc_col}, {50'b0, 7'd0, 7'd1});
    chk("t4_next_data", {48'b0, acc_data}, 64'd1);
    start_frame();
    @(negedge clk);
    chk("t5_ignored_busy", {63'b0, busy}, 64'd1);
    chk("t5_ignored_keeps_err", {63'b0, adc_err}, 64'd1);
    wait_idle(20000, "t4_idle");
    chk("t5_single_resv", 64'(n_resv - s_resv), 64'd1);
    chk("t5_single_done", 64'(n_done - s_done), 64'd1);
    chk("t4_err_sticky", {63'b0, adc_err}, 64'd1);
    no_done00 = 1'b0; mode = 0;
    start_frame();
    @(negedge clk);
    chk("t4_err_cleared", {63'b0, adc_err}, 64'd0);
    wait_idle(5000, "t4b_idle");

    // Reset during CONV aborts the scan
    mode = 1;
    start_frame();
    k = 0;
    do begin @(negedge clk); k++; end while (adc_start !== 1'b1 && k < 200);
    chk("t5_reached_conv", {63'b0, adc_start}, 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_reset_outputs",
        {25'b0, busy, frame_done, pixel_row, pixel_col, resv, incv, resp, incp,
         adc_start, pix_valid, pix_data, adc_err}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    s_resv = n_resv; s_resp = n_resp; s_incv = n_incv; s_incp = n_incp;
    s_start = n_start; s_acc = n_acc;
    repeat (20) @(negedge clk);
    chk("t5_quiet_after_reset",
        64'((n_resv - s_resv) + (n_resp - s_resp) + (n_incv - s_incv) +
            (n_incp - s_incp) + (n_start - s_start) + (n_acc - s_acc)), 64'd0);
    start_frame();
    k = 0;
    do begin @(negedge clk); k++; end while ({resv, resp, incv, incp} == 4'b0 && k < 20);
    chk("t5_restart_resv", {60'b0, resv, resp, incv, incp}, {60'b0, 4'b1000});
    mode = 0;
    wait_idle(20000, "t5_idle");

    chk("pulse_width", 64'(pw_err), 64'd0);
    chk("pulse_onehot", 64'(oh_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
